// File: rtl/aes_enc_core_hs.sv
// Iterative AES encryption core, one round per clock, valid/ready handshake on both sides.
// Optional CBC chaining is built in when the macro AES_CBC_EN is defined.
module aes_enc_core_hs #(
  parameter int NR    = 14,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] blk_cnt,
`ifdef AES_CBC_EN
  input  logic [127:0]     iv_in,
  input  logic             iv_load,
`endif
  // Round-key store lookup; rk_data must carry round key rk_idx in the same cycle.
  output logic [3:0]       rk_idx,
  input  logic [127:0]     rk_data
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_enc_core_hs: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_L   = 4'(NR);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as b^254 = b^2 * b^4 * ... * b^128, then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h01;
    x = b;
    for (int i = 0; i < 7; i++) begin
      x = gmul(x, x);
      r = gmul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  logic [1:0]       fsm_q, fsm_d;
  logic [127:0]     state_q, state_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [127:0]     out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [127:0]     pre_xor;
  logic [127:0]     rnd_out;
  logic             last_round;
  logic             slot_free;
  logic [7:0]       sb [16];
  logic [7:0]       sr [16];
  logic [7:0]       mc [16];

`ifdef AES_CBC_EN
  logic [127:0] chain_q, chain_d;
  // A same-cycle iv_load replaces the chain value for the block being accepted.
  assign pre_xor = iv_load ? iv_in : chain_q;
`else
  assign pre_xor = '0;
`endif

  assign last_round = (rnd_q == NR_L);
  assign slot_free  = !out_valid_q || out_ready;

  // Byte gi sits at row gi%4, column gi/4; byte 0 is the most significant.
  for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
    assign sb[gi] = sbox(state_q[127-8*gi -: 8]);
    assign sr[gi] = sb[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    assign mc[4*gi]   = xtime(sr[4*gi]) ^ xtime(sr[4*gi+1]) ^ sr[4*gi+1] ^ sr[4*gi+2] ^ sr[4*gi+3];
    assign mc[4*gi+1] = sr[4*gi] ^ xtime(sr[4*gi+1]) ^ xtime(sr[4*gi+2]) ^ sr[4*gi+2] ^ sr[4*gi+3];
    assign mc[4*gi+2] = sr[4*gi] ^ sr[4*gi+1] ^ xtime(sr[4*gi+2]) ^ xtime(sr[4*gi+3]) ^ sr[4*gi+3];
    assign mc[4*gi+3] = xtime(sr[4*gi]) ^ sr[4*gi] ^ sr[4*gi+1] ^ sr[4*gi+2] ^ xtime(sr[4*gi+3]);
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_ark
    assign rnd_out[127-8*gi -: 8] = (last_round ? sr[gi] : mc[gi]) ^ rk_data[127-8*gi -: 8];
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    rnd_d       = rnd_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    blk_cnt_d   = blk_cnt_q;
`ifdef AES_CBC_EN
    chain_d     = chain_q;
`endif
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (fsm_q)
      S_IDLE: begin
`ifdef AES_CBC_EN
        if (iv_load) chain_d = iv_in;
`endif
        if (in_valid) begin
          state_d = in_data ^ pre_xor ^ rk_data;
          rnd_d   = 4'd1;
          fsm_d   = S_RUN;
        end
      end
      S_RUN, S_WAIT: begin
        if (last_round) begin
          // WAIT recomputes the final round every cycle until the output slot frees.
          if (slot_free) begin
            out_data_d  = rnd_out;
            out_valid_d = 1'b1;
            done_d      = 1'b1;
            blk_cnt_d   = blk_cnt_q + CNT_W'(1);
            fsm_d       = S_IDLE;
`ifdef AES_CBC_EN
            chain_d     = rnd_out;
`endif
          end else begin
            fsm_d = S_WAIT;
          end
        end else begin
          state_d = rnd_out;
          rnd_d   = rnd_q + 4'd1;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      state_q     <= '0;
      rnd_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      blk_cnt_q   <= '0;
`ifdef AES_CBC_EN
      chain_q     <= '0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      blk_cnt_q   <= blk_cnt_d;
`ifdef AES_CBC_EN
      chain_q     <= chain_d;
`endif
    end
  end

  assign in_ready  = (fsm_q == S_IDLE);
  assign busy      = (fsm_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign blk_cnt   = blk_cnt_q;
  assign rk_idx    = (fsm_q == S_IDLE) ? 4'd0 : rnd_q;

endmodule

// File: tb/tb_aes_enc_core_hs.sv
// Bench for aes_enc_core_hs: NR=14 and NR=10 instances, software AES model feeding a scoreboard.
// CBC checks are included when AES_CBC_EN is defined.
module tb_aes_enc_core_hs;
  localparam int NR  = 14;
  localparam int NRB = 10;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C14 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C10 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_valid_b, out_ready;
  logic [127:0] in_data;
  logic         in_ready, out_valid, busy, done;
  logic         in_ready_b, out_valid_b, busy_b, done_b;
  logic [127:0] out_data, out_data_b, rk_data, rk_data_b;
  logic [31:0]  blk_cnt, blk_cnt_b;
  logic [3:0]   rk_idx, rk_idx_b;
`ifdef AES_CBC_EN
  logic [127:0] iv_in;
  logic         iv_load;
  logic         iv_load_b;
`endif

  logic [127:0] rk14 [0:14];
  logic [127:0] rk10 [0:10];
  logic [7:0]   sbx  [0:255];

  assign rk_data   = (rk_idx <= 4'd14) ? rk14[rk_idx] : '0;
  assign rk_data_b = (rk_idx_b <= 4'd10) ? rk10[rk_idx_b] : '0;

  aes_enc_core_hs #(.NR(NR), .CNT_W(32)) u14 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .done(done), .blk_cnt(blk_cnt),
`ifdef AES_CBC_EN
    .iv_in(iv_in), .iv_load(iv_load),
`endif
    .rk_idx(rk_idx), .rk_data(rk_data)
  );

  aes_enc_core_hs #(.NR(NRB), .CNT_W(32)) u10 (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .busy(busy_b),
    .done(done_b), .blk_cnt(blk_cnt_b),
`ifdef AES_CBC_EN
    .iv_in(iv_in), .iv_load(iv_load_b),
`endif
    .rk_idx(rk_idx_b), .rk_data(rk_data_b)
  );

  int total = 0;
  int bad   = 0;
  logic [127:0] sbq [$];
  logic [127:0] sbq_b [$];
  logic [127:0] mc_chain;

  // ---------------- software AES model ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic init_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ 8'h63;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbx[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbx[w[31:24]], sbx[w[23:16]], sbx[w[15:8]], sbx[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      if (nr == 14) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else          rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  function automatic logic [127:0] sw_enc(input logic [127:0] pt, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] k, res;
    k = (nr == 14) ? rk14[0] : rk10[0];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[w+4*c] = sbx[s[w + 4*((c + w) % 4)]];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gm(8'h02, t[4*c]) ^ gm(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gm(8'h02, t[4*c+1]) ^ gm(8'h03, t[4*c+2]) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(8'h02, t[4*c+2]) ^ gm(8'h03, t[4*c+3]);
          s[4*c+3] = gm(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gm(8'h02, t[4*c+3]);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      k = (nr == 14) ? rk14[r] : rk10[r];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected ciphertext for the NR=14 engine; in CBC builds the model chain advances.
  task automatic push14(input logic [127:0] pt);
    logic [127:0] e;
    e = sw_enc(pt ^ mc_chain, NR);
`ifdef AES_CBC_EN
    mc_chain = e;
`endif
    sbq.push_back(e);
  endtask

  function automatic logic [127:0] pop14();
    if (sbq.size() == 0) return 'x;
    return sbq.pop_front();
  endfunction

  // Accept one block on u14 and clock up to (and including) the final-round edge.
  task automatic run14(input logic [127:0] pt, output logic early);
    push14(pt);
    in_data  = pt;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    early = 1'b0;
    for (int k = 1; k < NR; k++) begin
      step();
      if (done !== 1'b0) early = 1'b1;
    end
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_valid_b = 1'b1; out_ready = 1'b1; in_data = PT;
`ifdef AES_CBC_EN
    iv_load = 1'b1; iv_load_b = 1'b0; iv_in = {4{32'hdeadbeef}};
`endif
    step(); step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (out_data !== 128'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    total++; if (blk_cnt !== 32'h0) begin bad++; $display("FAIL reset_blk_cnt got=%h want=0", blk_cnt); end
    rst = 1'b0; in_valid = 1'b0; in_valid_b = 1'b0;
`ifdef AES_CBC_EN
    iv_load = 1'b0;
`endif
    mc_chain = '0;
    sbq.delete(); sbq_b.delete();
    step();
  endtask

  task automatic test_nr14_kat();
    logic early;
    logic [127:0] e;
    out_ready = 1'b1;
    run14(PT, early);
    e = pop14();
    // Final round lands on edge T+14, so the consumer first samples out_valid at edge T+15.
    total++; if (early !== 1'b0) begin bad++; $display("FAIL kat14_early_done got=%b want=0", early); end
    total++; if (done !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL kat14_latency done=%b valid=%b want=1/1", done, out_valid); end
    total++; if (out_data !== C14) begin bad++; $display("FAIL kat14_data got=%h want=%h", out_data, C14); end
    total++; if (out_data !== e) begin bad++; $display("FAIL kat14_scoreboard got=%h want=%h", out_data, e); end
    total++; if (blk_cnt !== 32'd1) begin bad++; $display("FAIL kat14_blk_cnt got=%0d want=1", blk_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL kat14_in_ready got=%b want=1", in_ready); end
    $display("tx nr=14 ct=%h cnt=%0d", out_data, blk_cnt);
    step();
    total++; if (done !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL kat14_after done=%b valid=%b want=0/0", done, out_valid); end
  endtask

  task automatic test_nr10_kat();
    logic early;
    logic [127:0] e;
    out_ready = 1'b1;
    sbq_b.push_back(sw_enc(PT, NRB));
    in_data = PT; in_valid_b = 1'b1;
    step();
    in_valid_b = 1'b0;
    total++; if (busy_b !== 1'b1 || rk_idx_b !== 4'd1) begin bad++; $display("FAIL kat10_run busy=%b rk_idx=%0d want=1/1", busy_b, rk_idx_b); end
    early = 1'b0;
    for (int k = 1; k < NRB; k++) begin
      step();
      if (done_b !== 1'b0 || out_valid_b !== 1'b0) early = 1'b1;
    end
    step();
    e = (sbq_b.size() != 0) ? sbq_b.pop_front() : 'x;
    total++; if (early !== 1'b0) begin bad++; $display("FAIL kat10_early got=%b want=0", early); end
    total++; if (done_b !== 1'b1 || out_valid_b !== 1'b1) begin bad++; $display("FAIL kat10_latency done=%b valid=%b want=1/1", done_b, out_valid_b); end
    total++; if (out_data_b !== C10) begin bad++; $display("FAIL kat10_data got=%h want=%h", out_data_b, C10); end
    total++; if (out_data_b !== e) begin bad++; $display("FAIL kat10_scoreboard got=%h want=%h", out_data_b, e); end
    total++; if (blk_cnt_b !== 32'd1) begin bad++; $display("FAIL kat10_blk_cnt got=%0d want=1", blk_cnt_b); end
    $display("tx nr=10 ct=%h cnt=%0d", out_data_b, blk_cnt_b);
    step();
  endtask

  task automatic test_backpressure();
    logic early, moved;
    logic [127:0] e1, e2, p2;
    out_ready = 1'b0;
    run14(PT, early);
    e1 = pop14();
    total++; if (done !== 1'b1 || out_data !== e1) begin bad++; $display("FAIL bp_first done=%b got=%h want=%h", done, out_data, e1); end
    $display("tx nr=14 ct=%h cnt=%0d", out_data, blk_cnt);
    p2 = {$urandom, $urandom, $urandom, $urandom};
    run14(p2, early);
    moved = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (out_data !== e1 || done !== 1'b0) moved = 1'b1;
      step();
    end
    total++; if (moved !== 1'b0 || out_data !== e1) begin bad++; $display("FAIL bp_stable moved=%b got=%h want=%h", moved, out_data, e1); end
    total++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_wait busy=%b in_ready=%b valid=%b want=1/0/1", busy, in_ready, out_valid); end
    total++; if (blk_cnt !== 32'd1) begin bad++; $display("FAIL bp_cnt_wait got=%0d want=1", blk_cnt); end
    out_ready = 1'b1;
    step();
    e2 = pop14();
    total++; if (out_valid !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL bp_commit valid=%b done=%b want=1/1", out_valid, done); end
    total++; if (out_data !== e2) begin bad++; $display("FAIL bp_second got=%h want=%h", out_data, e2); end
    total++; if (blk_cnt !== 32'd2) begin bad++; $display("FAIL bp_cnt got=%0d want=2", blk_cnt); end
    $display("tx nr=14 ct=%h cnt=%0d", out_data, blk_cnt);
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_midop();
    logic early;
    logic [127:0] e;
    out_ready = 1'b0;
    run14(PT, early);
    void'(pop14());
    push14(128'h0f0e0d0c0b0a09080706050403020100);
    in_data = 128'h0f0e0d0c0b0a09080706050403020100; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    total++; if (rk_idx !== 4'd7) begin bad++; $display("FAIL mid_rnd got=%0d want=7", rk_idx); end
    rst = 1'b1;
    step();
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mid_idle in_ready=%b busy=%b want=1/0", in_ready, busy); end
    total++; if (out_valid !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_out valid=%b done=%b want=0/0", out_valid, done); end
    total++; if (blk_cnt !== 32'd0 || out_data !== 128'h0) begin bad++; $display("FAIL mid_regs cnt=%0d data=%h want=0/0", blk_cnt, out_data); end
    rst = 1'b0;
    sbq.delete();
    mc_chain = '0;
    out_ready = 1'b1;
    run14(PT, early);
    e = pop14();
    total++; if (done !== 1'b1 || out_data !== C14 || out_data !== e) begin bad++; $display("FAIL mid_fresh done=%b got=%h want=%h", done, out_data, C14); end
    total++; if (blk_cnt !== 32'd1) begin bad++; $display("FAIL mid_fresh_cnt got=%0d want=1", blk_cnt); end
    $display("tx nr=14 ct=%h cnt=%0d", out_data, blk_cnt);
    step();
  endtask

  task automatic test_cnt_wrap();
    logic early;
    logic [127:0] e;
    force u14.blk_cnt_q = '1;
    step();
    release u14.blk_cnt_q;
    out_ready = 1'b1;
    run14({$urandom, $urandom, $urandom, $urandom}, early);
    e = pop14();
    total++; if (done !== 1'b1 || out_data !== e) begin bad++; $display("FAIL wrap_data done=%b got=%h want=%h", done, out_data, e); end
    total++; if (blk_cnt !== 32'd0) begin bad++; $display("FAIL wrap_cnt got=%h want=0", blk_cnt); end
    $display("tx nr=14 ct=%h cnt=%0d", out_data, blk_cnt);
    step();
  endtask

  task automatic test_back_to_back();
    logic [127:0] p, e;
    logic early;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      run14(p, early);
      e = pop14();
      total++; if (done !== 1'b1 || early !== 1'b0) begin bad++; $display("FAIL b2b_timing blk=%0d done=%b early=%b want=1/0", i, done, early); end
      total++; if (out_data !== e) begin bad++; $display("FAIL b2b_data blk=%0d got=%h want=%h", i, out_data, e); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready blk=%0d got=%b want=1", i, in_ready); end
      $display("tx nr=14 ct=%h cnt=%0d", out_data, blk_cnt);
    end
    step();
  endtask

`ifdef AES_CBC_EN
  task automatic test_cbc();
    logic early;
    logic [127:0] e, p, iv3;
    out_ready = 1'b1;
    iv_in = '0; iv_load = 1'b1;
    step();
    iv_load = 1'b0;
    mc_chain = '0;
    run14(PT, early);
    e = pop14();
    total++; if (out_data !== C14 || out_data !== e) begin bad++; $display("FAIL cbc_c1 got=%h want=%h", out_data, C14); end
    $display("tx nr=14 cbc ct=%h", out_data);
    // Block 2 chains on C1; an iv_load while busy must be ignored.
    p = {$urandom, $urandom, $urandom, $urandom};
    push14(p);
    in_data = p; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k < NR; k++) begin
      iv_load = (k == 3); iv_in = {4{32'hcafef00d}};
      step();
    end
    iv_load = 1'b0;
    step();
    e = pop14();
    total++; if (done !== 1'b1 || out_data !== e) begin bad++; $display("FAIL cbc_c2 got=%h want=%h", out_data, e); end
    $display("tx nr=14 cbc ct=%h", out_data);
    // iv_load together with an accept uses iv_in directly for that block.
    iv3 = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom, $urandom, $urandom};
    mc_chain = iv3;
    push14(p);
    in_data = p; in_valid = 1'b1; iv_in = iv3; iv_load = 1'b1;
    step();
    in_valid = 1'b0; iv_load = 1'b0;
    for (int k = 1; k < NR; k++) step();
    step();
    e = pop14();
    total++; if (done !== 1'b1 || out_data !== e) begin bad++; $display("FAIL cbc_c3 got=%h want=%h", out_data, e); end
    $display("tx nr=14 cbc ct=%h", out_data);
    run14({$urandom, $urandom, $urandom, $urandom}, early);
    e = pop14();
    total++; if (done !== 1'b1 || out_data !== e) begin bad++; $display("FAIL cbc_c4 got=%h want=%h", out_data, e); end
    $display("tx nr=14 cbc ct=%h", out_data);
    step();
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_valid_b = 1'b0; out_ready = 1'b1; in_data = '0;
    mc_chain = '0;
`ifdef AES_CBC_EN
    iv_in = '0; iv_load = 1'b0; iv_load_b = 1'b0;
`endif
    init_sbox();
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    test_reset();
    test_nr14_kat();
    test_nr10_kat();
    test_reset();
    test_backpressure();
    test_reset();
    test_reset_midop();
    test_reset();
    test_cnt_wrap();
    test_reset();
    test_back_to_back();
`ifdef AES_CBC_EN
    test_reset();
    test_cbc();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
